// File: rtl/uart_echo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_echo_ctrl
// Description : Pops words from a UART receive FIFO, applies a selectable
//               transform and pushes the result into the transmit FIFO.
//               Transfers are started by a step tick or continuously when
//               auto_en is high. The transmit side stalls in WR while the
//               TX FIFO is full.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               step, auto_en       - transfer request controls
//               mode[1:0]           - 00 PASS, 01 ADD, 10 INVERT, 11 SWAPNIB
//               rx_empty, r_data    - receive FIFO status / head word
//               tx_full             - transmit FIFO full flag
//               rd_uart, wr_uart    - FIFO pop / push strobes
//               w_data              - word presented with wr_uart
//               last_rx             - most recently captured word
//               rx_count, tx_count  - popped / pushed word counters
//               busy                - FSM outside IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module uart_echo_ctrl #(
    parameter int DBIT  = 8,
    parameter int CNT_W = 16,
    parameter int INC   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic             auto_en,
    input  logic [1:0]       mode,
    input  logic             rx_empty,
    input  logic [DBIT-1:0]  r_data,
    input  logic             tx_full,
    output logic             rd_uart,
    output logic             wr_uart,
    output logic [DBIT-1:0]  w_data,
    output logic [DBIT-1:0]  last_rx,
    output logic [CNT_W-1:0] rx_count,
    output logic [CNT_W-1:0] tx_count,
    output logic             busy
);

    localparam int              c_half = DBIT / 2;
    localparam logic [DBIT-1:0] c_inc  = DBIT'(INC);

    localparam logic [1:0] c_mode_pass = 2'b00;
    localparam logic [1:0] c_mode_add  = 2'b01;
    localparam logic [1:0] c_mode_inv  = 2'b10;
    localparam logic [1:0] c_mode_swap = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    state_t            r_state;
    logic [DBIT-1:0]   r_capture;
    logic [1:0]        r_mode;
    logic [DBIT-1:0]   r_last_rx;
    logic [DBIT-1:0]   r_w_hold;
    logic [CNT_W-1:0]  r_rx_count;
    logic [CNT_W-1:0]  r_tx_count;
    logic [DBIT-1:0]   w_xform;
    logic              w_push;

    // Transform works only from the captured word and the mode latched in RD,
    // so later changes on the mode input cannot disturb a pending transfer.
    always_comb begin
        w_xform = r_capture;
        case (r_mode)
            c_mode_pass: w_xform = r_capture;
            c_mode_add:  w_xform = r_capture + c_inc;
            c_mode_inv:  w_xform = ~r_capture;
            c_mode_swap: w_xform = {r_capture[c_half-1:0], r_capture[DBIT-1:c_half]};
            default:     w_xform = r_capture;
        endcase
    end

    // The push strobe must react to tx_full in the same cycle, otherwise a
    // word could be pushed into a FIFO that just filled up.
    assign w_push = (r_state == WR) && !tx_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_capture  <= '0;
            r_mode     <= '0;
            r_last_rx  <= '0;
            r_w_hold   <= '0;
            r_rx_count <= '0;
            r_tx_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // A step that does not start a transfer is simply dropped.
                    if (!rx_empty && (auto_en || step)) begin
                        r_state <= RD;
                    end
                end
                RD: begin
                    r_capture  <= r_data;
                    r_last_rx  <= r_data;
                    r_mode     <= mode;
                    r_rx_count <= r_rx_count + 1'b1;
                    r_state    <= WR;
                end
                WR: begin
                    if (w_push) begin
                        r_w_hold   <= w_xform;
                        r_tx_count <= r_tx_count + 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rd_uart  = (r_state == RD);
    assign wr_uart  = w_push;
    // Between pushes the output keeps showing the last word actually pushed.
    assign w_data   = w_push ? w_xform : r_w_hold;
    assign last_rx  = r_last_rx;
    assign rx_count = r_rx_count;
    assign tx_count = r_tx_count;
    assign busy     = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_echo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_echo_ctrl
// Description : Self-checking bench for uart_echo_ctrl. A queue models the
//               receive FIFO; expected pushes go into a scoreboard queue and
//               are compared whenever wr_uart is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_echo_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        step = 1'b0;
    logic        auto_en = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        rx_empty = 1'b1;
    logic [7:0]  r_data = 8'h00;
    logic        tx_full = 1'b0;
    logic        rd_uart;
    logic        wr_uart;
    logic [7:0]  w_data;
    logic [7:0]  last_rx;
    logic [15:0] rx_count;
    logic [15:0] tx_count;
    logic        busy;

    uart_echo_ctrl #(.DBIT(8), .CNT_W(16), .INC(1)) dut (
        .clk      (clk),
        .reset    (reset),
        .step     (step),
        .auto_en  (auto_en),
        .mode     (mode),
        .rx_empty (rx_empty),
        .r_data   (r_data),
        .tx_full  (tx_full),
        .rd_uart  (rd_uart),
        .wr_uart  (wr_uart),
        .w_data   (w_data),
        .last_rx  (last_rx),
        .rx_count (rx_count),
        .tx_count (tx_count),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         rd_cnt = 0;
    logic [7:0] rx_q[$];
    logic [7:0] sb_q[$];
    int         push_cyc[$];

    typedef struct {
        logic [1:0] mode;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    vec_t vt[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic fifo_refresh();
        rx_empty = (rx_q.size() == 0);
        r_data   = rx_empty ? 8'h00 : rx_q[0];
    endtask

    task automatic fifo_push(input logic [7:0] d);
        rx_q.push_back(d);
        fifo_refresh();
    endtask

    always @(posedge clk) cyc++;

    // Receive FIFO model: the pop strobe seen at this edge removes the head.
    always @(posedge clk) begin
        if (rd_uart) begin
            #1;
            if (rx_q.size() > 0) void'(rx_q.pop_front());
            fifo_refresh();
        end
    end

    // Output monitor, sampled a little after the falling edge.
    always begin
        @(negedge clk);
        #2;
        if (rd_uart || wr_uart) check("strobe_exclusive", {30'd0, rd_uart, wr_uart} & 32'h3 & {30'd0, rd_uart && wr_uart, rd_uart && wr_uart}, 32'd0);
        if (rd_uart) rd_cnt++;
        if (wr_uart && !reset) begin
            push_cyc.push_back(cyc);
            if (sb_q.size() == 0) begin
                check("unexpected_push", {24'd0, w_data}, 32'hFFFF_FFFF);
            end else begin
                check("push_data", {24'd0, w_data}, {24'd0, sb_q.pop_front()});
            end
        end
    end

    task automatic step_pulse();
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        if (sb_q.size() != 0) begin
            check("push_timeout", sb_q.size(), 32'd0);
            sb_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rx_q.delete();
        sb_q.delete();
        fifo_refresh();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_zero_state(input string tag);
        check({tag, "_rd_uart"},  {31'd0, rd_uart}, 32'd0);
        check({tag, "_wr_uart"},  {31'd0, wr_uart}, 32'd0);
        check({tag, "_busy"},     {31'd0, busy},    32'd0);
        check({tag, "_w_data"},   {24'd0, w_data},  32'd0);
        check({tag, "_last_rx"},  {24'd0, last_rx}, 32'd0);
        check({tag, "_rx_count"}, {16'd0, rx_count}, 32'd0);
        check({tag, "_tx_count"}, {16'd0, tx_count}, 32'd0);
    endtask

    initial begin
        int rd_snap;
        int rx_snap;
        int tx_snap;
        int stall_bad;

        vt[0] = '{2'b01, 8'h41, 8'h42};
        vt[1] = '{2'b10, 8'h0F, 8'hF0};
        vt[2] = '{2'b11, 8'h3C, 8'hC3};
        vt[3] = '{2'b00, 8'hA5, 8'hA5};
        vt[4] = '{2'b01, 8'hFF, 8'h00};
        vt[5] = '{2'b10, 8'h00, 8'hFF};
        vt[6] = '{2'b11, 8'h12, 8'h21};

        @(negedge clk);
        do_reset();
        check_zero_state("reset");

        // Single-step transfers across every transform.
        for (int i = 0; i < 7; i++) begin
            mode = vt[i].mode;
            fifo_push(vt[i].data);
            sb_q.push_back(vt[i].exp);
            step_pulse();
            wait_drain(20);
            check("vec_last_rx", {24'd0, last_rx}, {24'd0, vt[i].data});
            if (i == 0) begin
                check("first_rx_count", {16'd0, rx_count}, 32'd1);
                check("first_tx_count", {16'd0, tx_count}, 32'd1);
            end
        end
        check("table_rx_count", {16'd0, rx_count}, 32'd7);
        check("table_tx_count", {16'd0, tx_count}, 32'd7);
        check("table_w_data_hold", {24'd0, w_data}, 32'h21);

        // Auto mode: back-to-back transfers at 3-cycle spacing.
        do_reset();
        mode = 2'b01;
        fifo_push(8'h00); fifo_push(8'hFF); fifo_push(8'h5A);
        sb_q.push_back(8'h01); sb_q.push_back(8'h00); sb_q.push_back(8'h5B);
        push_cyc.delete();
        auto_en = 1'b1;
        wait_drain(40);
        auto_en = 1'b0;
        check("auto_push_count", push_cyc.size(), 32'd3);
        if (push_cyc.size() == 3) begin
            check("auto_spacing_1", push_cyc[1] - push_cyc[0], 32'd3);
            check("auto_spacing_2", push_cyc[2] - push_cyc[1], 32'd3);
        end
        check("auto_rx_count", {16'd0, rx_count}, 32'd3);
        check("auto_tx_count", {16'd0, tx_count}, 32'd3);

        // Stall in WR for 10 cycles, then release.
        tx_full = 1'b1;
        mode = 2'b00;
        fifo_push(8'h77);
        sb_q.push_back(8'h77);
        step_pulse();
        @(negedge clk);
        stall_bad = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (wr_uart || !busy) stall_bad++;
            @(negedge clk);
        end
        check("stall_window_bad_cycles", stall_bad, 32'd0);
        tx_full = 1'b0;
        wait_drain(10);
        check("stall_idle_after", {31'd0, busy}, 32'd0);
        check("stall_tx_count", {16'd0, tx_count}, 32'd4);

        // Mode changed while the captured word waits in WR.
        tx_full = 1'b1;
        mode = 2'b01;
        fifo_push(8'h30);
        sb_q.push_back(8'h31);
        step_pulse();
        @(negedge clk);
        mode = 2'b10;
        repeat (3) @(negedge clk);
        tx_full = 1'b0;
        wait_drain(10);

        // Step with an empty FIFO is dropped, not queued.
        rd_snap = rd_cnt;
        rx_snap = rx_count;
        tx_snap = tx_count;
        step_pulse();
        fifo_push(8'h55);
        repeat (10) @(negedge clk);
        check("drop_rd_strobes", rd_cnt, rd_snap);
        check("drop_rx_count", {16'd0, rx_count}, rx_snap);
        check("drop_tx_count", {16'd0, tx_count}, tx_snap);
        rx_q.delete();
        fifo_refresh();

        // Reset while holding a word in WR discards it.
        tx_full = 1'b1;
        mode = 2'b00;
        fifo_push(8'h99);
        step_pulse();
        @(negedge clk);
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tx_full = 1'b0;
        check_zero_state("wr_reset");
        fifo_push(8'h10);
        sb_q.push_back(8'h10);
        step_pulse();
        wait_drain(20);
        check("post_reset_tx_count", {16'd0, tx_count}, 32'd1);
        check("post_reset_rx_count", {16'd0, rx_count}, 32'd1);
        check("post_reset_last_rx", {24'd0, last_rx}, 32'h10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, want completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/uart_echo_ctrl.md
UART_ECHO_CTRL -- requirements
Module: uart_echo_ctrl

Interface
REQ-001 Parameter DBIT, default 8: UART data word width in bits.
REQ-002 Parameter CNT_W, default 16: width of the byte counters.
REQ-003 Parameter INC, default 1: addend used in ADD mode; applied modulo 2^DBIT.
REQ-004 clk  input  1  single system clock; all state changes on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 step  input  1  single-cycle tick from the debouncer; requests one echo transfer.
REQ-007 auto_en  input  1  1 = echo continuously whenever data is available; 0 = one transfer per step tick.
REQ-008 mode  input  2  transform select: 00 PASS, 01 ADD, 10 INVERT, 11 SWAPNIB.
REQ-009 rx_empty  input  1  UART receive FIFO empty flag.
REQ-010 r_data  input  DBIT  head word of the UART receive FIFO.
REQ-011 tx_full  input  1  UART transmit FIFO full flag.
REQ-012 rd_uart  output  1  one-cycle pop strobe to the receive FIFO.
REQ-013 wr_uart  output  1  one-cycle push strobe to the transmit FIFO.
REQ-014 w_data  output  DBIT  transformed word presented with wr_uart.
REQ-015 last_rx  output  DBIT  most recently captured received word, for LED display.
REQ-016 rx_count  output  CNT_W  number of words popped since reset.
REQ-017 tx_count  output  CNT_W  number of words pushed since reset.
REQ-018 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, RD, and WR.
REQ-020 IDLE -> RD when rx_empty=0 and (auto_en=1 or step=1); otherwise remain in IDLE.
REQ-021 A step tick SHALL be ignored, not queued, if it arrives outside IDLE or while rx_empty=1.
REQ-022 In RD: rd_uart=1 for exactly that cycle; r_data loads a capture register and last_rx; mode is sampled into a mode register; rx_count increments; the next state is WR.
REQ-023 In WR with tx_full=0: wr_uart=1 and w_data=transform(capture, sampled mode); tx_count increments; the next state is IDLE.
REQ-024 In WR with tx_full=1: wr_uart=0 and the FSM remains in WR, holding the captured word indefinitely, with no timeout.
REQ-025 Transforms SHALL be as follows: PASS = word; ADD = (word + INC) mod 2^DBIT, discarding the carry; INVERT = bitwise NOT; SWAPNIB = upper and lower halves exchanged (DBIT must be even).
REQ-026 A mode change after RD SHALL NOT affect the word already captured.
REQ-027 Best-case latency SHALL be: condition seen in IDLE at cycle N -> rd_uart at N+1 -> wr_uart at N+2 -> IDLE at N+3, giving one transfer per 3 cycles maximum in auto mode.
REQ-028 rd_uart and wr_uart SHALL never be high in the same cycle; each strobe SHALL be high for at most one cycle per transfer.
REQ-029 Counters SHALL wrap from 2^CNT_W-1 to 0 without saturation or flag.
REQ-030 w_data SHALL hold the last pushed value between pushes.
REQ-031 busy SHALL be 1 in both RD and WR.
REQ-032 Toggling auto_en from 1 to 0 mid-transfer SHALL let the current transfer complete; no new transfer starts without a step tick.

Reset
REQ-033 While reset=1 at a clock edge: state goes to IDLE; rd_uart=0, wr_uart=0, busy=0; w_data, last_rx, rx_count, tx_count, the capture register, and the mode register all go to 0.
REQ-034 Reset asserted in WR SHALL discard the captured word; that word was already popped, so it is lost and rx_count minus tx_count is not preserved.
REQ-035 Reset SHALL take priority over every other input in the same cycle.

Verification
REQ-036 auto_en=0, mode=01, rx word 0x41, single step tick -> one rd_uart, then one wr_uart with w_data=0x42; rx_count=tx_count=1; last_rx=0x41.
REQ-037 auto_en=1, FIFO holds 0x00,0xFF,0x5A with mode=01 -> pushes 0x01,0x00,0x5B at 3-cycle spacing; counts reach 3.
REQ-038 mode=10 on 0x0F, then mode=11 on 0x3C -> pushes 0xF0, then 0xC3.
REQ-039 tx_full=1 held for 10 cycles in WR -> no wr_uart and busy=1 for the whole window; on release, exactly one push with the correct data, then IDLE.
REQ-040 step tick with rx_empty=1, then rx becomes non-empty with no further tick -> no strobes; counts unchanged.
REQ-041 reset pulse in WR, then a new word with a step tick -> all outputs read 0 after reset; the next transfer pushes only the new word and tx_count=1.
